// File: rtl/edge_frame_ctrl_pkg.sv
// Shared types and widths for the edge-detector frame controller.
package edge_frame_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARM    = 2'd1,
      ST_ACTIVE = 2'd2
   } state_e;

   localparam int CNT_W       = 12;
   localparam int FRAME_CNT_W = 16;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Geometry counters stick at full scale instead of wrapping to a bogus small count.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/edge_frame_ctrl_if.sv
// Video stream between grayscale source, frame controller and Sobel detector.
interface edge_frame_ctrl_if;

   // No ready exists: de qualifies data, the stream can never stall, and out_*
   // follow in_* by exactly one register stage whenever the controller forwards.
   logic       in_hsync;
   logic       in_vsync;
   logic       in_de;
   logic [7:0] in_data;
   logic       out_hsync;
   logic       out_vsync;
   logic       out_de;
   logic [7:0] out_data;

   modport master (
      output in_hsync, in_vsync, in_de, in_data,
      input  out_hsync, out_vsync, out_de, out_data
   );

   modport slave (
      input  in_hsync, in_vsync, in_de, in_data,
      output out_hsync, out_vsync, out_de, out_data
   );

endinterface

// File: rtl/frame_geom_check.sv
// Sync edge detection plus per-line pixel and per-frame line counting against
// the expected display geometry.
module frame_geom_check
   import edge_frame_ctrl_pkg::*;
#(
   parameter int H_DISP = 640,
   parameter int V_DISP = 480
) (
   input  logic clk,
   input  logic rst,
   input  logic in_vsync,
   input  logic in_de,
   output logic fb,
   output logic line_err,
   output logic frame_err
);

   localparam logic [CNT_W-1:0] H_CNT = CNT_W'(H_DISP);
   localparam logic [CNT_W-1:0] V_CNT = CNT_W'(V_DISP);

   logic             vsync_d;
   logic             de_d;
   logic             de_fall;
   logic [CNT_W-1:0] pix_cnt;
   logic [CNT_W-1:0] line_cnt;

   assign fb        = in_vsync & ~vsync_d;
   assign de_fall   = de_d & ~in_de;
   assign line_err  = de_fall & (pix_cnt != H_CNT);
   assign frame_err = fb & (line_cnt != V_CNT);

   // A frame boundary restarts both counts; the line just finished is judged
   // on the cycle de falls, before its pixel count is discarded.
   always_ff @(posedge clk) begin
      if (rst) begin
         vsync_d  <= 1'b0;
         de_d     <= 1'b0;
         pix_cnt  <= '0;
         line_cnt <= '0;
      end else begin
         vsync_d <= in_vsync;
         de_d    <= in_de;
         if (fb) begin
            pix_cnt  <= '0;
            line_cnt <= '0;
         end else if (in_de) begin
            pix_cnt <= sat_inc(pix_cnt);
         end else begin
            pix_cnt <= '0;
            if (de_fall) line_cnt <= sat_inc(line_cnt);
         end
      end
   end

endmodule

// File: rtl/edge_frame_ctrl.sv
// Frame-aligned gate in front of the Sobel detector: run/stop/single-shot,
// shadowed threshold, frame counting and sticky geometry errors.
module edge_frame_ctrl
   import edge_frame_ctrl_pkg::*;
#(
   parameter int H_DISP = 640,
   parameter int V_DISP = 480
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cfg_run,
   input  logic                   cfg_single,
   input  logic [7:0]             cfg_value,
   input  logic                   err_clr,
   edge_frame_ctrl_if.slave       vid,
   output logic [7:0]             value_out,
   output logic                   busy,
   output logic                   frame_done,
   output logic [FRAME_CNT_W-1:0] frame_cnt,
   output logic                   err_line,
   output logic                   err_frame,
   output state_e                 dbg_state
);

   state_e state;
   state_e state_nxt;
   logic   single_flag;
   logic   single_nxt;
   logic   fwd;
   logic   load_value;
   logic   frame_end;
   logic   fb;
   logic   line_err;
   logic   frame_err;

   frame_geom_check #(
      .H_DISP (H_DISP),
      .V_DISP (V_DISP)
   ) u_geom (
      .clk       (clk),
      .rst       (rst),
      .in_vsync  (vid.in_vsync),
      .in_de     (vid.in_de),
      .fb        (fb),
      .line_err  (line_err),
      .frame_err (frame_err)
   );

   // fwd marks cycles whose input is passed on; the boundary cycle that opens
   // a forwarded frame is forwarded, the one that closes the last frame is not.
   always_comb begin
      state_nxt  = state;
      single_nxt = single_flag;
      fwd        = 1'b0;
      load_value = 1'b0;
      frame_end  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (cfg_run || cfg_single) begin
               state_nxt  = ST_ARM;
               single_nxt = cfg_single;
            end
         end
         ST_ARM: begin
            if (fb) begin
               state_nxt  = ST_ACTIVE;
               load_value = 1'b1;
               fwd        = 1'b1;
            end
         end
         ST_ACTIVE: begin
            if (fb) begin
               frame_end = 1'b1;
               if (single_flag || !cfg_run) begin
                  state_nxt  = ST_IDLE;
                  single_nxt = 1'b0;
               end else begin
                  load_value = 1'b1;
                  fwd        = 1'b1;
               end
            end else begin
               fwd = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         single_flag <= 1'b0;
      end else begin
         state       <= state_nxt;
         single_flag <= single_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vid.out_hsync <= 1'b0;
         vid.out_vsync <= 1'b0;
         vid.out_de    <= 1'b0;
         vid.out_data  <= '0;
      end else begin
         vid.out_hsync <= fwd & vid.in_hsync;
         vid.out_vsync <= fwd & vid.in_vsync;
         vid.out_de    <= fwd & vid.in_de;
         vid.out_data  <= fwd ? vid.in_data : '0;
      end
   end

   // A new error event in the same cycle as err_clr keeps the flag set.
   always_ff @(posedge clk) begin
      if (rst) begin
         value_out  <= '0;
         frame_done <= 1'b0;
         frame_cnt  <= '0;
         err_line   <= 1'b0;
         err_frame  <= 1'b0;
      end else begin
         if (load_value) value_out <= cfg_value;
         frame_done <= frame_end;
         if (frame_end) frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
         err_line  <= (line_err && state == ST_ACTIVE) || (err_line && !err_clr);
         err_frame <= (frame_end && frame_err) || (err_frame && !err_clr);
      end
   end

   assign busy      = (state != ST_IDLE);
   assign dbg_state = state;

endmodule

// File: doc/edge_frame_ctrl.md
# edge_frame_ctrl

Frame-level controller between the grayscale source and the Sobel edge detector. It gates the pixel stream into the detector on whole-frame boundaries only, supporting run, stop and single-shot operation. It shadow-registers the edge threshold so a new value never takes effect mid-frame. It checks every frame's geometry against H_DISP×V_DISP and reports frame completion and errors.

## Interface
- H_DISP, 640, active pixels per line
- V_DISP, 480, active lines per frame
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- cfg_run  in  1  level; continuous frame forwarding while high
- cfg_single  in  1  one-cycle pulse; forward exactly one frame
- cfg_value  in  8  requested threshold
- err_clr  in  1  pulse; clears sticky error flags
- in_hsync, in_vsync, in_de  in  1 each  source syncs / data enable
- in_data  in  8  source gray pixel
- out_hsync, out_vsync, out_de  out  1 each  gated syncs to detector
- out_data  out  8  gated pixel to detector
- value_out  out  8  threshold applied to detector (shadow register)
- busy  out  1  high in ARM or ACTIVE
- frame_done  out  1  one-cycle pulse at each forwarded frame's end
- frame_cnt  out  16  forwarded frames since reset, wraps at 65535→0
- err_line  out  1  sticky: some line had de-count ≠ H_DISP
- err_frame  out  1  sticky: some frame had line count ≠ V_DISP

## Operation
- Frame boundary (FB): cycle where in_vsync is 1 and was 0 the previous cycle (registered edge detect).
- States: IDLE, ARM, ACTIVE.
- IDLE: on cfg_run=1 or cfg_single pulse → ARM. Latch a single-shot flag when cfg_single is pulsed.
- ARM: on FB → ACTIVE. In the same cycle, value_out ← cfg_value, and the pixel and line counters clear.
- ACTIVE: forward the stream. On each in_de falling edge: compare the pixel count with H_DISP; set err_line on mismatch; increment the line count.
- ACTIVE on FB (frame end):
  - pulse frame_done; increment frame_cnt; set err_frame if line count ≠ V_DISP.
  - If the single-shot flag is set or cfg_run=0 → IDLE and clear the flag; the FB cycle is not forwarded.
  - Otherwise stay ACTIVE, reload value_out from cfg_value, clear counters, and forward the FB cycle as the start of the next frame.
- cfg_run dropping mid-frame: the current frame completes; there is no truncation.
- cfg_single while busy: ignored.
- cfg_single and cfg_run both high: run takes precedence; the single flag still forces IDLE at the next frame end.
- Pixel and line counters are 12 bits and saturate at 4095.
- err_clr clears both sticky flags. A set event in the same cycle wins over err_clr.
- When not ACTIVE, all out_* are 0 and in_data is not propagated.

## Timing
- Forwarded path: one register stage. out_* at cycle n+1 equals in_* at cycle n while ACTIVE.
- value_out changes in the FB cycle, so it is stable before the first forwarded pixel (one cycle later).
- frame_done, frame_cnt increment, and err_frame update all occur in the cycle after FB. err_line updates the cycle after the de falling edge.
- Reset values: state IDLE, all out_*=0, value_out=0, busy=0, frame_done=0, frame_cnt=0, err_line=0, err_frame=0, counters=0, edge-detect history=0.
- Reset mid-frame: return to IDLE immediately. A vsync already high at reset release is not an FB; the controller waits for a fresh 0→1 transition.

## Structure
- Shared package: state enum (IDLE/ARM/ACTIVE), counter width constant (12), frame_cnt width (16).
- One natural sub-module: frame_geom_check, which holds the de/vsync edge detectors, pixel/line counters and comparisons, and emits line_err and frame_err strobes. The FSM, gating and shadow register stay in the top.

## Test plan
- Reset, cfg_run=1, 3 clean 640×480 frames → frame_cnt=3, three frame_done pulses, errors 0, out_* equal in_* delayed one cycle.
- cfg_value changed 50→80 mid-frame 2 → value_out stays 50 until FB of frame 3, then 80.
- Single pulse in IDLE → exactly one frame forwarded, then IDLE. out_de stays 0 for the following frame.
- Line 100 carries 639 de cycles → err_line=1 one cycle after that line ends. err_clr then clears it. Err_clr coincident with a new error → flag stays 1.
- Frame with 479 lines → err_frame=1 at the next FB. frame_cnt still increments.
- rst asserted mid-frame with vsync high at release → no forwarding until the next 0→1 vsync edge. All outputs 0 during reset.
